// File: rtl/eda_pixel_stack.sv
// LIFO work-list for the regional-maxima flood fill: serializes 8-neighbour push masks into a stack and pops center pixels.
// Optional build macro EDA_PIXEL_STACK_DEDUP_EN skips pushes of addresses already on the stack.
module eda_pixel_stack #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int WINDOW_WIDTH = 9,
  parameter int ADDR_WIDTH   = $clog2(M*N),
  parameter int DEPTH        = M*N,
  parameter int CNT_WIDTH    = $clog2(DEPTH+1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic                      seed_valid,
  input  logic [ADDR_WIDTH-1:0]     seed_addr,
  output logic                      seed_ready,
  input  logic                      push_valid,
  input  logic [WINDOW_WIDTH-2:0]   push_positions,
  input  logic [ADDR_WIDTH-1:0]     upleft_addr,
  input  logic [ADDR_WIDTH-1:0]     up_addr,
  input  logic [ADDR_WIDTH-1:0]     upright_addr,
  input  logic [ADDR_WIDTH-1:0]     left_addr,
  input  logic [ADDR_WIDTH-1:0]     right_addr,
  input  logic [ADDR_WIDTH-1:0]     downleft_addr,
  input  logic [ADDR_WIDTH-1:0]     down_addr,
  input  logic [ADDR_WIDTH-1:0]     downright_addr,
  output logic                      push_ready,
  input  logic                      pop_req,
  output logic [ADDR_WIDTH-1:0]     center_addr,
  output logic                      new_pixel,
  output logic                      region_done,
  output logic                      empty,
  output logic                      full,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      overflow
);

  localparam int NB    = WINDOW_WIDTH - 1;
  localparam int IDX_W = $clog2(NB);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] POP  = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] sp;
  logic [NB-1:0]         mask_p0;
  logic [NB-1:0]         mask_next;
  logic [ADDR_WIDTH-1:0] nb_addr_p0 [NB];
  logic [ADDR_WIDTH-1:0] nb_in [NB];
  logic [ADDR_WIDTH-1:0] stack_mem [DEPTH];

  logic                  push_take;
  logic                  pop_take;
  logic                  seed_take;
  logic                  dup;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] cur_addr;

  function automatic logic [IDX_W-1:0] lsb_idx(input logic [NB-1:0] m);
    lsb_idx = '0;
    for (int b = NB - 1; b >= 0; b--)
      if (m[b]) lsb_idx = b[IDX_W-1:0];
  endfunction

  // Index 0 is downright so the lowest set bit is pushed first and upleft ends on top.
  assign nb_in[7] = upleft_addr;
  assign nb_in[6] = up_addr;
  assign nb_in[5] = upright_addr;
  assign nb_in[4] = left_addr;
  assign nb_in[3] = right_addr;
  assign nb_in[2] = downleft_addr;
  assign nb_in[1] = down_addr;
  assign nb_in[0] = downright_addr;

  assign empty      = (count == '0);
  assign full       = (count == CNT_WIDTH'(DEPTH));
  assign push_ready = (state != PUSH);
  assign seed_ready = (state == IDLE) && empty && !push_valid;

  assign push_take  = push_valid && push_ready && (push_positions != '0);
  assign pop_take   = (state == IDLE) && !push_take && pop_req && !empty;
  assign seed_take  = (state == IDLE) && seed_valid && seed_ready;

  assign mask_next  = mask_p0 & (mask_p0 - NB'(1));
  assign cur_addr   = nb_addr_p0[lsb_idx(mask_p0)];
  assign rd_data    = stack_mem[sp - ADDR_WIDTH'(1)];
  assign wr_en      = seed_take || ((state == PUSH) && !full && !dup);
  assign wr_data    = seed_take ? seed_addr : cur_addr;

`ifdef EDA_PIXEL_STACK_DEDUP_EN
  logic [DEPTH-1:0] on_stack;

  assign dup = on_stack[cur_addr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_stack <= '0;
    end else if (clear) begin
      on_stack <= '0;
    end else begin
      if (wr_en)         on_stack[wr_data] <= 1'b1;
      if (state == POP)  on_stack[rd_data] <= 1'b0;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Capture stage: neighbour addresses and stack storage carry no reset.
  always_ff @(posedge clk) begin
    if (push_take) nb_addr_p0 <= nb_in;
    if (wr_en)     stack_mem[sp] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sp          <= '0;
      count       <= '0;
      mask_p0     <= '0;
      center_addr <= '0;
      new_pixel   <= 1'b0;
      region_done <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      sp          <= '0;
      count       <= '0;
      mask_p0     <= '0;
      center_addr <= '0;
      new_pixel   <= 1'b0;
      region_done <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      new_pixel   <= 1'b0;
      region_done <= 1'b0;
      if (push_take) mask_p0 <= push_positions;
      case (state)
        IDLE: begin
          if (push_take) begin
            state <= PUSH;
          end else if (pop_take) begin
            state <= POP;
          end else if (seed_take) begin
            sp    <= sp + ADDR_WIDTH'(1);
            count <= count + CNT_WIDTH'(1);
          end
        end
        PUSH: begin
          mask_p0 <= mask_next;
          if (!dup) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              sp    <= sp + ADDR_WIDTH'(1);
              count <= count + CNT_WIDTH'(1);
            end
          end
          if (mask_next == '0) state <= IDLE;
        end
        POP: begin
          center_addr <= rd_data;
          new_pixel   <= 1'b1;
          sp          <= sp - ADDR_WIDTH'(1);
          count       <= count - CNT_WIDTH'(1);
          // A mask captured alongside the last pop means the region continues.
          region_done <= (count == CNT_WIDTH'(1)) && !push_take;
          state       <= push_take ? PUSH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eda_pixel_stack.sv
// Scoreboard bench for eda_pixel_stack: a reference LIFO predicts each popped pixel and region_done flag.
module tb_eda_pixel_stack;

  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       seed_valid;
  logic [7:0] seed_addr;
  logic       seed_ready;
  logic       push_valid;
  logic [7:0] push_positions;
  logic [7:0] nb [8];
  logic       push_ready;
  logic       pop_req;
  logic [7:0] center_addr;
  logic       new_pixel;
  logic       region_done;
  logic       empty;
  logic       full;
  logic [8:0] count;
  logic       overflow;

  eda_pixel_stack dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clear          (clear),
    .seed_valid     (seed_valid),
    .seed_addr      (seed_addr),
    .seed_ready     (seed_ready),
    .push_valid     (push_valid),
    .push_positions (push_positions),
    .upleft_addr    (nb[7]),
    .up_addr        (nb[6]),
    .upright_addr   (nb[5]),
    .left_addr      (nb[4]),
    .right_addr     (nb[3]),
    .downleft_addr  (nb[2]),
    .down_addr      (nb[1]),
    .downright_addr (nb[0]),
    .push_ready     (push_ready),
    .pop_req        (pop_req),
    .center_addr    (center_addr),
    .new_pixel      (new_pixel),
    .region_done    (region_done),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic       last;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model [$];
  logic       ovf_exp;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_model(input logic [7:0] a);
    foreach (model[i]) if (model[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Reference effect of a mask: bit0 first, drops at DEPTH, optional duplicate skip.
  task automatic model_push(input logic [7:0] m);
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
`ifdef EDA_PIXEL_STACK_DEDUP_EN
        if (in_model(nb[b])) continue;
`endif
        if (model.size() >= DEPTH) ovf_exp = 1'b1;
        else model.push_back(nb[b]);
      end
    end
  endtask

  task automatic push_mask(input logic [7:0] m);
    int zc;
    push_valid     = 1'b1;
    push_positions = m;
    tick();
    push_valid     = 1'b0;
    push_positions = '0;
    model_push(m);
    zc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (push_ready) break;
      zc++;
    end
    check("push_cycles", zc, $countones(m));
  endtask

  task automatic expect_pop();
    exp_t e;
    e.addr = model.pop_back();
    e.last = (model.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic do_pop();
    expect_pop();
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check("pop_lat1", new_pixel, 1'b0);
    @(negedge clk);
    check("pop_lat2", new_pixel, 1'b1);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && new_pixel) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("center_addr", center_addr, e.addr);
        check("region_done", region_done, e.last);
      end
    end else if (reset_n && region_done) begin
      check("stray_region_done", 1'b1, 1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int zc;
    reset_n = 1'b0; clear = 1'b0; seed_valid = 1'b0; seed_addr = '0;
    push_valid = 1'b0; push_positions = '0; pop_req = 1'b0; ovf_exp = 1'b0;
    for (int b = 0; b < 8; b++) nb[b] = 8'(b);
    #22;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_new_pixel", new_pixel, 0);
    check("rst_region_done", region_done, 0);
    check("rst_center", center_addr, 0);
    check("rst_push_ready", push_ready, 1);
    check("rst_seed_ready", seed_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Seed then pop a single-pixel region.
    seed_valid = 1'b1; seed_addr = 8'h23;
    #1 check("seed_ready", seed_ready, 1);
    tick();
    seed_valid = 1'b0;
    model.push_back(8'h23);
    check("seed_count", count, 1);
    do_pop();
    check("seed_empty", empty, 1);

    // Zero mask is a no-op; pops on an empty stack are ignored.
    push_mask(8'h00);
    check("zero_mask_count", count, 0);
    pop_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("empty_pop_np", new_pixel, 0);
    end
    pop_req = 1'b0;
    check("empty_pop_count", count, 0);

    // Two-bit mask: upleft pops before downright.
    nb[7] = 8'h10; nb[0] = 8'h32;
    push_mask(8'h81);
    check("m81_count", count, 2);
    do_pop();
    do_pop();
    check("m81_empty", empty, 1);

    // Full mask with pop_req held: pop waits for serialization.
    for (int b = 0; b < 8; b++) nb[b] = 8'hA0 + 8'(b);
    push_valid = 1'b1; push_positions = 8'hFF; pop_req = 1'b1;
    tick();
    push_valid = 1'b0; push_positions = '0;
    model_push(8'hFF);
    zc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (push_ready) break;
      zc++;
    end
    check("stall_cycles", zc, 8);
    check("stall_count", count, 8);
    expect_pop();
    tick();
    pop_req = 1'b0;
    @(negedge clk);
    check("stall_lat1", new_pixel, 0);
    @(negedge clk);
    check("stall_lat2", new_pixel, 1);
    for (int i = 0; i < 7; i++) do_pop();
    check("stall_empty", empty, 1);

    // Fill to DEPTH, then overflow.
    for (int k = 0; k < 32; k++) begin
      for (int b = 0; b < 8; b++) nb[b] = 8'(k * 8 + b);
      push_mask(8'hFF);
    end
    check("fill_count", count, DEPTH);
    check("fill_full", full, 1);
    check("fill_seed_ready", seed_ready, 0);
    check("fill_overflow", overflow, 0);
    for (int b = 0; b < 8; b++) nb[b] = 8'h55;
    push_mask(8'h03);
    check("ovf_flag", overflow, ovf_exp);
    check("ovf_count", count, DEPTH);
    do_pop();
    check("ovf_sticky", overflow, 1);
    check("ovf_pop_count", count, DEPTH - 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model.delete();
    ovf_exp = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_empty", empty, 1);
    check("clr_count", count, 0);
    check("clr_full", full, 0);

    // Asynchronous reset in the middle of serialization.
    for (int b = 0; b < 8; b++) nb[b] = 8'hC0 + 8'(b);
    push_valid = 1'b1; push_positions = 8'hF0;
    tick();
    push_valid = 1'b0; push_positions = '0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_new_pixel", new_pixel, 0);
    check("arst_empty", empty, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_push_ready", push_ready, 1);
    check("arst_count_after", count, 0);
    seed_valid = 1'b1; seed_addr = 8'h5A;
    tick();
    seed_valid = 1'b0;
    model.push_back(8'h5A);
    do_pop();

    // Repeated address through two masks.
    nb[3] = 8'h44;
`ifdef EDA_PIXEL_STACK_DEDUP_EN
    push_mask(8'h08);
    push_mask(8'h08);
    check("dedup_count", count, 1);
    do_pop();
    push_mask(8'h08);
    check("dedup_again", count, 1);
    do_pop();
`else
    push_mask(8'h08);
    push_mask(8'h08);
    check("dup_count", count, 2);
    do_pop();
    do_pop();
`endif
    check("final_empty", empty, 1);

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/eda_pixel_stack.md
Name: eda_pixel_stack

Overview:
- LIFO work-list for the regional-maxima flood fill. Sits directly upstream of the visited-pixel memory.
- Captures the 8-neighbour push mask and neighbour addresses from the window compare stage, then serializes them into a stack.
- Pops entries to issue the next center_addr with a one-cycle new_pixel pulse.
- Also accepts a seed pixel to start a region and flags region completion.

Parameters:
- M, 16, image rows
- N, 16, image columns
- WINDOW_WIDTH, 9, window size; the neighbour count is WINDOW_WIDTH-1 = 8
- ADDR_WIDTH, $clog2(M*N), pixel address {i, j}
- DEPTH, M*N, stack entries
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of the stack, pending mask and flags
- seed_valid  in  1  request to push seed_addr
- seed_addr  in  ADDR_WIDTH  start pixel of a region
- seed_ready  out  1  seed accepted this cycle when seed_valid is also high
- push_valid  in  1  neighbour mask and addresses are valid
- push_positions  in  WINDOW_WIDTH-1  bit7 upleft, up, upright, left, right, downleft, down, bit0 downright
- upleft_addr, up_addr, upright_addr, left_addr, right_addr, downleft_addr, down_addr, downright_addr  in  ADDR_WIDTH each  neighbour addresses
- push_ready  out  1  mask capture possible
- pop_req  in  1  consumer requests the next pixel
- center_addr  out  ADDR_WIDTH  popped pixel address
- new_pixel  out  1  one-cycle strobe; center_addr is valid
- region_done  out  1  one-cycle pulse when the fill drains
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  CNT_WIDTH  occupancy
- overflow  out  1  sticky: a push was dropped because the stack was full

Behaviour:
- Reset (asynchronous, reset_n low):
  - state IDLE, count 0, stack pointer 0, pending mask 0.
  - Outputs: center_addr 0, new_pixel 0, region_done 0, overflow 0, empty 1, full 0.
  - push_ready and seed_ready are combinational; they follow the rules below from the first cycle.
- FSM states: IDLE, PUSH, POP.
- IDLE:
  - push_ready = 1.
  - seed_ready = empty and no push_valid.
  - Accepted push_valid with a nonzero mask: latch the mask and all 8 addresses, go to PUSH.
  - Accepted push_valid with a zero mask: no-op.
  - Else pop_req with !empty: go to POP.
  - Else accepted seed: write seed_addr, count+1.
- PUSH:
  - push_ready = 0, seed_ready = 0.
  - Each cycle, push the address of the lowest set mask bit and clear that bit.
  - Bit0 (downright) is pushed first and bit7 (upleft) last, so upleft pops first.
  - Return to IDLE in the cycle the last bit clears. A k-bit mask takes k cycles.
- POP:
  - Read the top entry, count-1.
  - center_addr and new_pixel are registered outputs valid the next cycle. Latency from pop_req to new_pixel is 2 cycles.
  - Return to IDLE.
- Priority: clear > push serialization > pop > seed. A pop_req during PUSH is held off, not lost; the consumer keeps it asserted.
- Full stack:
  - A push when count == DEPTH drops that address and sets overflow.
  - Pointer and count are unchanged and the remaining mask bits still drain.
  - overflow clears only on reset or clear.
- pop_req while empty: ignored, no new_pixel.
- region_done: pulses one cycle with the new_pixel of the pop that makes count 0, provided no push was captured in that cycle.
- clear: resets everything as reset does, except it takes effect on the clock edge. A clear mid-PUSH abandons the pending mask.
- The stack is a register or RAM array with a single write and a single read port. Entries are not cleared by clear.

Optional Feature:
- Macro: EDA_PIXEL_STACK_DEDUP_EN.
- When defined:
  - An M x N on-stack bitmap is set on each push and cleared on each pop.
  - A push whose address bit is already set is skipped; it costs the cycle but is not written and does not raise overflow.
  - clear zeros the bitmap.
- When undefined: duplicates are pushed normally.

Test Plan:
- Seed 0x23 with the stack empty → seed_ready=1, count=1. Then pop_req → new_pixel with center_addr=0x23 two cycles later, region_done pulses, empty=1.
- Push mask 0x81 with upleft=0x10 and downright=0x32 → 2 PUSH cycles, count=2. Two pops return 0x10 then 0x32.
- Push mask 0xFF while pop_req is held → pop stalls 8 cycles, push_ready=0 for 8 cycles. The first pop returns upleft_addr.
- Fill to DEPTH=256, then push mask 0x03 → both dropped, overflow=1, count=256. clear → overflow=0, empty=1.
- Assert reset_n low mid-PUSH with mask 0xF0 → immediately count=0, new_pixel=0. After release, push_ready=1.
- With EDA_PIXEL_STACK_DEDUP_EN defined, push 0x44 twice via two masks → count=1. Pop, then push 0x44 again → count=1.
